// File: rtl/bus_initiator.sv
// Initiator end of the daisy-chained register bus: one host request in flight, launched as a
// single-cycle bus beat and completed when it returns from the chain. Optional WAIT timeout: BUS_INITIATOR_TIMEOUT_EN.
module bus_initiator #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] req_addr_i,
    input  logic [15:0] req_wdata_i,
    input  logic        req_rw_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    output logic [15:0] resp_rdata_o,
    output logic        resp_rw_o,
    output logic        resp_err_o,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [15:0] bus_addr_o,
    output logic [15:0] bus_wdata_o,
    output logic [15:0] bus_rdata_o,
    output logic        bus_rw_o,
    output logic        bus_valid_o,
    input  logic [15:0] bus_addr_i,
    input  logic [15:0] bus_wdata_i,
    input  logic [15:0] bus_rdata_i,
    input  logic        bus_rw_i,
    input  logic        bus_valid_i
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("bus_initiator: TIMEOUT must be in 1..65535");
    end

    state_t      state, state_nxt;
    logic [15:0] cap_addr, cap_addr_nxt;
    logic [15:0] cap_wdata, cap_wdata_nxt;
    logic        cap_rw, cap_rw_nxt;
    logic        req_ready_nxt;
    logic [15:0] resp_rdata_nxt;
    logic        resp_rw_nxt, resp_err_nxt, resp_valid_nxt;
    logic [15:0] bus_addr_nxt, bus_wdata_nxt;
    logic        bus_rw_nxt, bus_valid_nxt;
    logic        match, rw_err;
`ifdef BUS_INITIATOR_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);
    logic [15:0] cnt, cnt_nxt;
`endif

    // The returning write data is never needed by the initiator.
    logic unused_ret;
    assign unused_ret = ^bus_wdata_i;

    assign match  = bus_valid_i && (bus_addr_i == cap_addr);
    assign rw_err = (bus_rw_i != cap_rw);

    always_comb begin
        state_nxt      = state;
        cap_addr_nxt   = cap_addr;
        cap_wdata_nxt  = cap_wdata;
        cap_rw_nxt     = cap_rw;
        req_ready_nxt  = req_ready_o;
        resp_rdata_nxt = resp_rdata_o;
        resp_rw_nxt    = resp_rw_o;
        resp_err_nxt   = resp_err_o;
        resp_valid_nxt = resp_valid_o;
        bus_addr_nxt   = bus_addr_o;
        bus_wdata_nxt  = bus_wdata_o;
        bus_rw_nxt     = bus_rw_o;
        bus_valid_nxt  = bus_valid_o;
`ifdef BUS_INITIATOR_TIMEOUT_EN
        cnt_nxt        = cnt;
`endif
        case (state)
            IDLE: begin
                req_ready_nxt = 1'b1;
                if (req_valid_i && req_ready_o) begin
                    cap_addr_nxt  = req_addr_i;
                    cap_wdata_nxt = req_wdata_i;
                    cap_rw_nxt    = req_rw_i;
                    req_ready_nxt = 1'b0;
                    // Bus outputs are registered, so the beat is loaded here to appear during ISSUE.
                    bus_valid_nxt = 1'b1;
                    bus_addr_nxt  = req_addr_i;
                    bus_wdata_nxt = req_wdata_i;
                    bus_rw_nxt    = req_rw_i;
                    state_nxt     = ISSUE;
                end
            end
            ISSUE: begin
                bus_valid_nxt = 1'b0;
                bus_addr_nxt  = 16'h0000;
                bus_wdata_nxt = 16'h0000;
                bus_rw_nxt    = 1'b0;
`ifdef BUS_INITIATOR_TIMEOUT_EN
                cnt_nxt       = 16'h0000;
`endif
                state_nxt     = WAIT;
            end
            WAIT: begin
                if (match) begin
                    resp_valid_nxt = 1'b1;
                    resp_err_nxt   = rw_err;
                    resp_rw_nxt    = cap_rw;
                    resp_rdata_nxt = (!cap_rw && !rw_err) ? bus_rdata_i : 16'h0000;
                    state_nxt      = RESP;
                end
`ifdef BUS_INITIATOR_TIMEOUT_EN
                else if (cnt + 16'd1 == TIMEOUT_CNT) begin
                    resp_valid_nxt = 1'b1;
                    resp_err_nxt   = 1'b1;
                    resp_rw_nxt    = cap_rw;
                    resp_rdata_nxt = 16'h0000;
                    state_nxt      = RESP;
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
`endif
            end
            RESP: begin
                if (resp_ready_i) begin
                    resp_valid_nxt = 1'b0;
                    resp_err_nxt   = 1'b0;
                    resp_rw_nxt    = 1'b0;
                    resp_rdata_nxt = 16'h0000;
                    req_ready_nxt  = 1'b1;
                    state_nxt      = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cap_addr     <= 16'h0000;
            cap_wdata    <= 16'h0000;
            cap_rw       <= 1'b0;
            req_ready_o  <= 1'b0;
            resp_rdata_o <= 16'h0000;
            resp_rw_o    <= 1'b0;
            resp_err_o   <= 1'b0;
            resp_valid_o <= 1'b0;
            bus_addr_o   <= 16'h0000;
            bus_wdata_o  <= 16'h0000;
            bus_rw_o     <= 1'b0;
            bus_valid_o  <= 1'b0;
`ifdef BUS_INITIATOR_TIMEOUT_EN
            cnt          <= 16'h0000;
`endif
        end else begin
            state        <= state_nxt;
            cap_addr     <= cap_addr_nxt;
            cap_wdata    <= cap_wdata_nxt;
            cap_rw       <= cap_rw_nxt;
            req_ready_o  <= req_ready_nxt;
            resp_rdata_o <= resp_rdata_nxt;
            resp_rw_o    <= resp_rw_nxt;
            resp_err_o   <= resp_err_nxt;
            resp_valid_o <= resp_valid_nxt;
            bus_addr_o   <= bus_addr_nxt;
            bus_wdata_o  <= bus_wdata_nxt;
            bus_rw_o     <= bus_rw_nxt;
            bus_valid_o  <= bus_valid_nxt;
`ifdef BUS_INITIATOR_TIMEOUT_EN
            cnt          <= cnt_nxt;
`endif
        end
    end

    // Read data is never driven toward the chain; responders fill it in.
    assign bus_rdata_o = 16'h0000;

endmodule
